// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the framed fabric configuration loader.
//   cfg_state_t : loader FSM states
//   SYNC_WORD   : frame start marker hunted before the payload
//   CRC_POLY/CRC_INIT : CRC-8 parameters covering the payload bits
//   crc8_next   : one-bit MSB-first CRC-8 update
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    LOAD  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } cfg_state_t;

  localparam logic [7:0] SYNC_WORD = 8'hA5;
  localparam logic [7:0] CRC_POLY  = 8'h07;
  localparam logic [7:0] CRC_INIT  = 8'h00;

  // Serial CRC-8 step: shift left, fold in the polynomial when the outgoing
  // MSB differs from the incoming bit.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ din) == 1'b1) ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 accumulator over the configuration payload.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : reload CRC_INIT (takes priority over enable)
//   enable    : fold data_bit into the CRC this cycle
//   data_bit  : serial payload bit, MSB first
//   crc       : running CRC value
module cfg_crc8
  import fpga_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_bit,
  output logic [7:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc8_next(crc, data_bit);
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Framed configuration loader: hunts SYNC_WORD, distributes CHAINS*CHAIN_LEN
// payload bits over CHAINS parallel config chains, checks a trailing CRC-8
// and releases the fabric reset only after a good load. Old chain-0 contents
// are streamed out on prog_out for readback.
//   clk, rst    : clock, asynchronous active-high reset
//   prog_en     : programming window; a rising edge restarts a load
//   prog_in     : serial bitstream, MSB first, sampled while prog_en=1
//   cfg_tail    : tail bit of each config chain
//   cfg_shift   : one-cycle shift strobe to all chains
//   cfg_data    : head bits presented with cfg_shift
//   prog_out    : readback of cfg_tail[0], updated on each shift
//   fabric_rst  : held high until a load passes
//   cfg_done    : last load passed the CRC check
//   cfg_err     : last load was aborted or failed the CRC check
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned CHAINS    = 1,
  parameter int unsigned CHAIN_LEN = 160
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_en,
  input  logic              prog_in,
  input  logic [CHAINS-1:0] cfg_tail,
  output logic              cfg_shift,
  output logic [CHAINS-1:0] cfg_data,
  output logic              prog_out,
  output logic              fabric_rst,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int unsigned SW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned GW = (CHAINS > 1) ? $clog2(CHAINS) : 1;

  cfg_state_t        state;
  logic              prev_en;
  logic [7:0]        win;
  logic [SW-1:0]     shift_cnt;
  logic [GW-1:0]     grp_cnt;
  logic [CHAINS-1:0] acc;
  logic [2:0]        chk_cnt;
  logic [7:0]        crc;

  logic              rise_c;
  logic              crc_en_c;
  logic              grp_last_c;
  logic [7:0]        win_next_c;
  logic [CHAINS-1:0] group_next_c;

  // Only chain 0 is read back; the other tails are intentionally ignored.
  logic unused_tail;
  assign unused_tail = ^cfg_tail;

  assign rise_c     = prog_en & ~prev_en;
  assign crc_en_c   = (state == LOAD) && prog_en && !rise_c;
  assign grp_last_c = (grp_cnt == GW'(CHAINS - 1));
  assign win_next_c = {win[6:0], prog_in};

  // Current group with the incoming bit dropped into its chain slot.
  always_comb begin
    group_next_c = acc;
    for (int i = 0; i < int'(CHAINS); i++) begin
      if (grp_cnt == GW'(i)) begin
        group_next_c[i] = prog_in;
      end
    end
  end

  cfg_crc8 u_crc (
    .clk      (clk),
    .rst      (rst),
    .clear    (rise_c),
    .enable   (crc_en_c),
    .data_bit (prog_in),
    .crc      (crc)
  );

  // Loader FSM, counters, group assembly and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev_en    <= 1'b0;
      win        <= 8'h00;
      shift_cnt  <= '0;
      grp_cnt    <= '0;
      acc        <= '0;
      chk_cnt    <= 3'd0;
      cfg_shift  <= 1'b0;
      cfg_data   <= '0;
      prog_out   <= 1'b0;
      fabric_rst <= 1'b1;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      prev_en   <= prog_en;
      cfg_shift <= 1'b0;

      // Readback samples the old tail on the edge that ends a shift cycle.
      if (cfg_shift) begin
        prog_out <= cfg_tail[0];
      end

      if (rise_c) begin
        // The bit arriving with the rising edge is the first sync-hunt bit.
        state      <= SYNC;
        fabric_rst <= 1'b1;
        cfg_done   <= 1'b0;
        cfg_err    <= 1'b0;
        win        <= {7'b0, prog_in};
        shift_cnt  <= '0;
        grp_cnt    <= '0;
        acc        <= '0;
        chk_cnt    <= 3'd0;
      end else if ((state inside {SYNC, LOAD, CHECK}) && !prog_en) begin
        // Window closed mid-frame: chains keep whatever was shifted so far.
        state      <= ERR;
        cfg_err    <= 1'b1;
        fabric_rst <= 1'b1;
      end else begin
        case (state)
          SYNC: begin
            win <= win_next_c;
            if (win_next_c == SYNC_WORD) begin
              state <= LOAD;
            end
          end
          LOAD: begin
            acc <= group_next_c;
            if (grp_last_c) begin
              cfg_data  <= group_next_c;
              cfg_shift <= 1'b1;
              grp_cnt   <= '0;
              shift_cnt <= shift_cnt + 1'b1;
              if (shift_cnt == SW'(CHAIN_LEN - 1)) begin
                state   <= CHECK;
                chk_cnt <= 3'd0;
              end
            end else begin
              grp_cnt <= grp_cnt + 1'b1;
            end
          end
          CHECK: begin
            win     <= win_next_c;
            chk_cnt <= chk_cnt + 1'b1;
            if (chk_cnt == 3'd7) begin
              if (win_next_c == crc) begin
                state      <= DONE;
                cfg_done   <= 1'b1;
                fabric_rst <= 1'b0;
              end else begin
                state      <= ERR;
                cfg_err    <= 1'b1;
                fabric_rst <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: instance a (CHAINS=1, CHAIN_LEN=8) with a
// modelled chain 0 for readback, instance b (CHAINS=4, CHAIN_LEN=2).
module tb_fpga_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  = 1'b0;
  logic en_a = 1'b0, in_a = 1'b0;
  logic en_b = 1'b0, in_b = 1'b0;

  logic       a_shift, a_po, a_frst, a_done, a_err;
  logic [0:0] a_data;
  logic [0:0] a_tail;
  logic       b_shift, b_po, b_frst, b_done, b_err;
  logic [3:0] b_data;
  logic [3:0] b_tail = 4'b0000;

  logic [7:0] chain_a;
  logic       exp_po;

  logic [0:0] q_a[$];
  logic [3:0] q_b[$];

  int n_chk  = 0;
  int n_pass = 0;

  fpga_cfg_loader #(.CHAINS(1), .CHAIN_LEN(8)) u_a (
    .clk(clk), .rst(rst), .prog_en(en_a), .prog_in(in_a), .cfg_tail(a_tail),
    .cfg_shift(a_shift), .cfg_data(a_data), .prog_out(a_po),
    .fabric_rst(a_frst), .cfg_done(a_done), .cfg_err(a_err)
  );

  fpga_cfg_loader #(.CHAINS(4), .CHAIN_LEN(2)) u_b (
    .clk(clk), .rst(rst), .prog_en(en_b), .prog_in(in_b), .cfg_tail(b_tail),
    .cfg_shift(b_shift), .cfg_data(b_data), .prog_out(b_po),
    .fabric_rst(b_frst), .cfg_done(b_done), .cfg_err(b_err)
  );

  // Chain-0 model for instance a: preloaded so the tail reads 1,0,1,1,0,0,1,0.
  assign a_tail = chain_a[7];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_a <= 8'b1011_0010;
      exp_po  <= 1'b0;
    end else if (a_shift) begin
      exp_po  <= chain_a[7];
      chain_a <= {chain_a[6:0], a_data[0]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and readback monitor, sampled mid-cycle.
  always @(negedge clk) begin
    chk("a_prog_out", 32'(a_po), 32'(exp_po));
    chk("b_prog_out", 32'(b_po), 32'(1'b0));
    if (a_shift) begin
      chk("a_shift_expected", 32'(q_a.size() != 0), 32'(1'b1));
      if (q_a.size() != 0) chk("a_cfg_data", 32'(a_data), 32'(q_a.pop_front()));
    end
    if (b_shift) begin
      chk("b_shift_expected", 32'(q_b.size() != 0), 32'(1'b1));
      if (q_b.size() != 0) chk("b_cfg_data", 32'(b_data), 32'(q_b.pop_front()));
    end
  end

  function automatic logic [7:0] crc8(input logic [7:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ (((c[7] ^ d[3'(i)]) == 1'b1) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [2:0] st(input bit sel);
    return sel ? {b_frst, b_done, b_err} : {a_frst, a_done, a_err};
  endfunction

  // Called at a negedge: apply inputs, return at the next negedge.
  task automatic drive(input bit sel, input logic en, input logic b);
    if (sel) begin
      en_b = en; in_b = b;
    end else begin
      en_a = en; in_a = b;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) drive(sel, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) drive(sel, 1'b1, v[3'(i)]);
  endtask

  task automatic send_payload(input bit sel, input logic [7:0] p, input int n);
    logic [3:0] g;
    logic       bb;
    g = 4'b0000;
    for (int i = 0; i < n; i++) begin
      bb = p[3'(7 - i)];
      if (!sel) begin
        q_a.push_back(bb);
      end else begin
        g[2'(i % 4)] = bb;
        if (i % 4 == 3) q_b.push_back(g);
      end
      drive(sel, 1'b1, bb);
    end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] p, input logic [7:0] c);
    send_byte(sel, 8'hA5, 8);
    send_payload(sel, p, 8);
    send_byte(sel, c, 7);
    chk("pre_last_crc_status", 32'(st(sel)), 32'(3'b100));
    drive(sel, 1'b1, c[0]);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values hold with the window closed.
    for (int i = 0; i < 20; i++) begin
      chk("a_reset_outputs", 32'({a_frst, a_shift, a_data, a_po, a_done, a_err}), 32'(6'b100000));
      chk("b_reset_outputs", 32'({b_frst, b_shift, b_data, b_po, b_done, b_err}), 32'(9'b1_0_0000_0_0_0));
      @(negedge clk);
    end

    // Good frame on a: payload 0x01, CRC 0x07.
    send_frame(1'b0, 8'h01, 8'h07);
    chk("a_good_frame", 32'(st(1'b0)), 32'(3'b010));
    idle(1'b0, 5);
    chk("a_done_hold", 32'(st(1'b0)), 32'(3'b010));

    // Same payload with a wrong CRC.
    send_frame(1'b0, 8'h01, 8'h06);
    chk("a_bad_crc", 32'(st(1'b0)), 32'(3'b101));
    idle(1'b0, 3);
    chk("a_err_hold", 32'(st(1'b0)), 32'(3'b101));

    // Abort after 3 payload bits, then re-rise the very next cycle.
    send_byte(1'b0, 8'hA5, 8);
    send_payload(1'b0, 8'hE0, 3);
    chk("a_loading_status", 32'(st(1'b0)), 32'(3'b100));
    drive(1'b0, 1'b0, 1'b0);
    chk("a_abort", 32'(st(1'b0)), 32'(3'b101));
    send_frame(1'b0, 8'h5C, crc8(8'h5C));
    chk("a_recover", 32'(st(1'b0)), 32'(3'b010));
    idle(1'b0, 2);

    // Asynchronous reset in the middle of a load.
    send_byte(1'b0, 8'hA5, 8);
    send_payload(1'b0, 8'hA0, 3);
    chk("a_shift_before_rst", 32'({a_shift, a_data}), 32'(2'b11));
    #2;
    rst  = 1'b1;
    en_a = 1'b0;
    in_a = 1'b0;
    #1;
    chk("a_async_rst", 32'({a_frst, a_shift, a_data, a_po, a_done, a_err}), 32'(6'b100000));
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0, 3);
    chk("a_after_rst", 32'(st(1'b0)), 32'(3'b100));
    send_frame(1'b0, 8'h01, 8'h07);
    chk("a_frame_after_rst", 32'(st(1'b0)), 32'(3'b010));

    // Four chains: payload 1,0,1,1,0,0,1,0 -> groups 4'b1101, 4'b0100.
    send_frame(1'b1, 8'hB2, crc8(8'hB2));
    chk("b_good_frame", 32'(st(1'b1)), 32'(3'b010));
    idle(1'b1, 3);

    // Window closes exactly when the last CRC bit would be sampled.
    send_byte(1'b1, 8'hA5, 8);
    send_payload(1'b1, 8'h3C, 8);
    send_byte(1'b1, crc8(8'h3C), 7);
    drive(1'b1, 1'b0, crc8(8'h3C) & 8'h01 ? 1'b1 : 1'b0);
    chk("b_drop_last_crc", 32'(st(1'b1)), 32'(3'b101));
    idle(1'b1, 2);
    send_frame(1'b1, 8'h3C, crc8(8'h3C));
    chk("b_recover", 32'(st(1'b1)), 32'(3'b010));
    idle(1'b1, 3);

    chk("a_queue_drained", 32'(q_a.size()), 32'(0));
    chk("b_queue_drained", 32'(q_b.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
